// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-ported data memory between the pipeline MEM
// stage (priority) and a secondary burst requester (test loader / DMA).
// Secondary beats use cycles the MEM stage leaves idle.
// Optional feature macro: DMEM_ARB_STARVE_EN. When it is defined, a starvation
// counter forces a secondary beat through after STARVE_MAX consecutive denied
// cycles, and it stalls the pipeline for that cycle. When it is undefined, the
// secondary port waits for a free cycle indefinitely, and p_stall stays 0.
module dmem_arbiter #(
   parameter int unsigned LEN_W      = 4,
   parameter int unsigned STARVE_MAX = 8
) (
   input  logic             clk,
   input  logic             rst,
   // pipeline MEM stage
   input  logic             p_read,
   input  logic             p_write,
   input  logic [31:0]      p_addr,
   input  logic [31:0]      p_wdata,
   output logic [31:0]      p_rdata,
   output logic             p_stall,
   // secondary burst port
   input  logic             b_req,
   input  logic             b_we,
   input  logic [31:0]      b_addr,
   input  logic [LEN_W-1:0] b_len,
   input  logic [31:0]      b_wdata,
   output logic             b_ack,
   output logic             b_beat,
   output logic             b_rvalid,
   output logic [31:0]      b_rdata,
   output logic             b_done,
   // data memory
   output logic             m_read,
   output logic             m_write,
   output logic [31:0]      m_addr,
   output logic [31:0]      m_wdata,
   input  logic [31:0]      m_rdata
);

   typedef enum logic [0:0] {StIdle, StXfer} state_e;

   state_e           state_q, state_d;
   logic [31:0]      cur_addr_q, cur_addr_d;
   logic [LEN_W-1:0] beats_left_q, beats_left_d;
   logic             dir_q, dir_d;
   logic [31:0]      b_rdata_q, b_rdata_d;
   logic             b_rvalid_q, b_rvalid_d;
   logic             b_done_q, b_done_d;

   logic             p_busy;
   logic             force_beat;
   logic             beat;

   assign p_busy = p_read | p_write;

`ifdef DMEM_ARB_STARVE_EN
   localparam int unsigned StarveW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

   logic [StarveW-1:0] starve_cnt_q, starve_cnt_d;

   // A force cycle takes memory regardless of pipeline traffic.
   assign force_beat = (state_q == StXfer) && (starve_cnt_q == StarveW'(STARVE_MAX));
`else
   assign force_beat = 1'b0;
`endif

   assign beat = (state_q == StXfer) && (!p_busy || force_beat);

   // Memory-side mux: the pipeline passes through unless a secondary beat owns the cycle.
   always_comb begin
      m_read  = p_read;
      m_write = p_write;
      m_addr  = p_addr;
      m_wdata = p_wdata;
      if (beat) begin
         m_read  = ~dir_q;
         m_write = dir_q;
         m_addr  = cur_addr_q;
         m_wdata = b_wdata;
      end
   end

   assign p_rdata  = m_rdata;
   assign b_beat   = beat;
   // Gating with rst keeps b_ack low while reset is held, even though the state already reads idle.
   assign b_ack    = (state_q == StIdle) && b_req && !rst;
   assign b_rvalid = b_rvalid_q;
   assign b_rdata  = b_rdata_q;
   assign b_done   = b_done_q;

`ifdef DMEM_ARB_STARVE_EN
   assign p_stall = beat && p_busy;
`else
   assign p_stall = 1'b0;
`endif

   // Next-state logic: burst acceptance, beat advance, read capture and completion.
   always_comb begin
      state_d      = state_q;
      cur_addr_d   = cur_addr_q;
      beats_left_d = beats_left_q;
      dir_d        = dir_q;
      b_rdata_d    = b_rdata_q;
      b_rvalid_d   = 1'b0;
      b_done_d     = 1'b0;
`ifdef DMEM_ARB_STARVE_EN
      starve_cnt_d = starve_cnt_q;
`endif
      case (state_q)
         StIdle: begin
            if (b_ack) begin
               cur_addr_d   = b_addr;
               beats_left_d = b_len;
               dir_d        = b_we;
               state_d      = StXfer;
`ifdef DMEM_ARB_STARVE_EN
               starve_cnt_d = '0;
`endif
            end
         end
         StXfer: begin
            if (beat) begin
               cur_addr_d = cur_addr_q + 32'd4;
`ifdef DMEM_ARB_STARVE_EN
               starve_cnt_d = '0;
`endif
               if (!dir_q) begin
                  b_rdata_d  = m_rdata;
                  b_rvalid_d = 1'b1;
               end
               if (beats_left_q == '0) begin
                  state_d  = StIdle;
                  b_done_d = 1'b1;
               end else begin
                  beats_left_d = beats_left_q - 1'b1;
               end
            end else begin
`ifdef DMEM_ARB_STARVE_EN
               // Denied cycle: count toward the force threshold, saturating there.
               if (starve_cnt_q != StarveW'(STARVE_MAX)) begin
                  starve_cnt_d = starve_cnt_q + 1'b1;
               end
`endif
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers; reset aborts any burst without issuing b_done.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         cur_addr_q   <= '0;
         beats_left_q <= '0;
         dir_q        <= 1'b0;
         b_rdata_q    <= '0;
         b_rvalid_q   <= 1'b0;
         b_done_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         cur_addr_q   <= cur_addr_d;
         beats_left_q <= beats_left_d;
         dir_q        <= dir_d;
         b_rdata_q    <= b_rdata_d;
         b_rvalid_q   <= b_rvalid_d;
         b_done_q     <= b_done_d;
      end
   end

`ifdef DMEM_ARB_STARVE_EN
   // Starvation counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt_q <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
      end
   end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized and directed stimulus for dmem_arbiter.
// The expected outputs come from a transaction-level reference model. Each
// accepted burst becomes a queue of beat addresses, and the reference memory
// is a plain word array.
module tb_dmem_arbiter;

   localparam int unsigned LEN_W      = 4;
   localparam int unsigned STARVE_MAX = 8;
`ifdef DMEM_ARB_STARVE_EN
   localparam bit StarveEn = 1'b1;
`else
   localparam bit StarveEn = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic             p_read, p_write;
   logic [31:0]      p_addr, p_wdata, p_rdata;
   logic             p_stall;
   logic             b_req, b_we;
   logic [31:0]      b_addr;
   logic [LEN_W-1:0] b_len;
   logic [31:0]      b_wdata;
   logic             b_ack, b_beat, b_rvalid, b_done;
   logic [31:0]      b_rdata;
   logic             m_read, m_write;
   logic [31:0]      m_addr, m_wdata, m_rdata;

   dmem_arbiter #(
      .LEN_W     (LEN_W),
      .STARVE_MAX(STARVE_MAX)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .p_read  (p_read),
      .p_write (p_write),
      .p_addr  (p_addr),
      .p_wdata (p_wdata),
      .p_rdata (p_rdata),
      .p_stall (p_stall),
      .b_req   (b_req),
      .b_we    (b_we),
      .b_addr  (b_addr),
      .b_len   (b_len),
      .b_wdata (b_wdata),
      .b_ack   (b_ack),
      .b_beat  (b_beat),
      .b_rvalid(b_rvalid),
      .b_rdata (b_rdata),
      .b_done  (b_done),
      .m_read  (m_read),
      .m_write (m_write),
      .m_addr  (m_addr),
      .m_wdata (m_wdata),
      .m_rdata (m_rdata)
   );

   always #5 clk = ~clk;

   // Data memory: combinational read, write on negedge inside the cycle.
   logic [31:0] dev_mem [256];
   assign m_rdata = dev_mem[m_addr[9:2]];
   always @(negedge clk) if (m_write) dev_mem[m_addr[9:2]] <= m_wdata;

   // Reference model state.
   logic [31:0] ref_mem [256];
   logic [31:0] beat_q [$];
   bit          xfer_m;
   bit          dir_m;
   int          wait_m;
   bit          rvalid_m, done_m;
   logic [31:0] rdata_m;

   int checks   = 0;
   int failures = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      beat_q.delete();
      xfer_m   = 1'b0;
      dir_m    = 1'b0;
      wait_m   = 0;
      rvalid_m = 1'b0;
      done_m   = 1'b0;
      rdata_m  = '0;
   endtask

   // One clock cycle. Call it at posedge+1. It drives the inputs, checks every output
   // against the model at posedge+4 (before the memory's negedge write), then advances.
   task automatic step(input bit pr, input bit pw, input logic [31:0] pa, input logic [31:0] pwd,
                       input bit br, input bit bwe, input logic [31:0] ba,
                       input logic [LEN_W-1:0] bl, input logic [31:0] bwd);
      bit          e_ack, e_beat;
      logic [31:0] baddr, e_maddr;
      p_read = pr; p_write = pw; p_addr = pa; p_wdata = pwd;
      b_req = br; b_we = bwe; b_addr = ba; b_len = bl; b_wdata = bwd;
      #3;
      e_ack   = !xfer_m && br;
      e_beat  = xfer_m && (!(pr || pw) || (StarveEn && wait_m == int'(STARVE_MAX)));
      baddr   = e_beat ? beat_q[0] : 32'h0;
      e_maddr = e_beat ? baddr : pa;
      check_eq("b_ack", 32'(b_ack), 32'(e_ack));
      check_eq("b_beat", 32'(b_beat), 32'(e_beat));
      check_eq("p_stall", 32'(p_stall), 32'(e_beat && (pr || pw)));
      check_eq("m_read", 32'(m_read), 32'(e_beat ? !dir_m : pr));
      check_eq("m_write", 32'(m_write), 32'(e_beat ? dir_m : pw));
      check_eq("m_addr", m_addr, e_maddr);
      check_eq("m_wdata", m_wdata, e_beat ? bwd : pwd);
      check_eq("p_rdata", p_rdata, ref_mem[e_maddr[9:2]]);
      check_eq("b_rvalid", 32'(b_rvalid), 32'(rvalid_m));
      check_eq("b_done", 32'(b_done), 32'(done_m));
      check_eq("b_rdata", b_rdata, rdata_m);
      rvalid_m = 1'b0;
      done_m   = 1'b0;
      if (e_beat) begin
         void'(beat_q.pop_front());
         if (dir_m) ref_mem[baddr[9:2]] = bwd;
         else begin
            rvalid_m = 1'b1;
            rdata_m  = ref_mem[baddr[9:2]];
         end
         wait_m = 0;
         if (beat_q.size() == 0) begin
            xfer_m = 1'b0;
            done_m = 1'b1;
         end
      end else begin
         if (pw) ref_mem[pa[9:2]] = pwd;
         if (xfer_m && wait_m < int'(STARVE_MAX)) wait_m++;
      end
      if (e_ack) begin
         beat_q.delete();
         for (int i = 0; i <= int'(bl); i++) beat_q.push_back(ba + 32'(4 * i));
         xfer_m = 1'b1;
         dir_m  = bwe;
         wait_m = 0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, '0, 32'h0);
   endtask

   initial begin
      logic [31:0] v;
      for (int i = 0; i < 256; i++) begin
         v = $urandom;
         dev_mem[i] = v;
         ref_mem[i] = v;
      end
      model_reset();
      rst = 1'b1;
      p_read = 0; p_write = 0; p_addr = 32'h0; p_wdata = 32'h0;
      b_req = 1; b_we = 0; b_addr = 32'h0; b_len = '0; b_wdata = 32'h0;
      @(posedge clk); @(posedge clk); #1;
      // Reset state; b_req is held high to show that b_ack is gated.
      check_eq("rst_b_ack", 32'(b_ack), 32'h0);
      check_eq("rst_b_beat", 32'(b_beat), 32'h0);
      check_eq("rst_p_stall", 32'(p_stall), 32'h0);
      check_eq("rst_m_rw", {30'h0, m_read, m_write}, 32'h0);
      check_eq("rst_b_rvalid", 32'(b_rvalid), 32'h0);
      check_eq("rst_b_done", 32'(b_done), 32'h0);
      check_eq("rst_b_rdata", b_rdata, 32'h0);
      rst = 1'b0;

      // Write burst of 4 beats at 0x40 on an idle bus.
      step(0, 0, 32'h0, 32'h0, 1, 1, 32'h40, 4'd3, 32'h0);
      for (int i = 0; i < 4; i++) step(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, '0, 32'(i + 1));
      idle(2);
      for (int i = 0; i < 4; i++) check_eq("wr_burst_mem", dev_mem[16 + i], 32'(i + 1));

      // Read burst of 2 beats at 0x0 from known words.
      dev_mem[0] = 32'd16817; ref_mem[0] = 32'd16817;
      dev_mem[1] = 32'd16801; ref_mem[1] = 32'd16801;
      step(0, 0, 32'h0, 32'h0, 1, 0, 32'h0, 4'd1, 32'h0);
      step(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, '0, 32'h0);
      check_eq("rd_first_rvalid", 32'(b_rvalid), 32'h1);
      check_eq("rd_first_rdata", b_rdata, 32'd16817);
      step(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, '0, 32'h0);
      check_eq("rd_second_rdata", b_rdata, 32'd16801);
      check_eq("rd_second_done", 32'(b_done), 32'h1);
      idle(2);

      // Single-beat write under continuous p_read: force cycle only when starvation is enabled.
      step(1, 0, 32'h300, 32'h0, 1, 1, 32'h100, 4'd0, 32'h0);
      for (int i = 0; i < 10; i++) step(1, 0, 32'h300, 32'h0, 0, 0, 32'h0, '0, 32'hABCD0000 + 32'(i));
      idle(3);

      // 4-beat read with alternating pipeline writes and idle cycles.
      step(0, 0, 32'h0, 32'h0, 1, 0, 32'h200, 4'd3, 32'h0);
      for (int i = 0; i < 10; i++) begin
         if (i % 2 == 0) step(0, 1, 32'h380 + 32'(4 * i), $urandom, 0, 0, 32'h0, '0, 32'h0);
         else step(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, '0, 32'h0);
      end
      idle(2);

      // Asynchronous reset after beat 2 of a 4-beat read.
      step(0, 0, 32'h0, 32'h0, 1, 0, 32'h80, 4'd3, 32'h0);
      idle(2);
      p_read = 0; p_write = 0; b_req = 1; b_we = 0; b_addr = 32'h0;
      #2 rst = 1'b1;
      #1;
      check_eq("arst_b_beat", 32'(b_beat), 32'h0);
      check_eq("arst_b_ack", 32'(b_ack), 32'h0);
      check_eq("arst_b_rvalid", 32'(b_rvalid), 32'h0);
      check_eq("arst_b_rdata", b_rdata, 32'h0);
      check_eq("arst_m_rw", {30'h0, m_read, m_write}, 32'h0);
      @(posedge clk); #1;
      check_eq("arst_no_done", 32'(b_done), 32'h0);
      rst = 1'b0;
      model_reset();
      step(0, 0, 32'h0, 32'h0, 1, 1, 32'h20, 4'd0, 32'h5A5A5A5A);
      idle(3);

      // Address wrap at the top of the 32-bit space.
      step(0, 0, 32'h0, 32'h0, 1, 1, 32'hFFFFFFFC, 4'd1, 32'h0);
      step(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, '0, 32'h11111111);
      step(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, '0, 32'h22222222);
      idle(2);

      // Randomized traffic in heavy and light pipeline-load phases.
      for (int blk = 0; blk < 40; blk++) begin
         int heavy;
         heavy = (blk % 3 == 0) ? 1 : 0;
         for (int c = 0; c < 40; c++) begin
            bit busy, pr, pw;
            busy = heavy ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 9) < 3);
            pr = busy && $urandom_range(0, 2) != 0;
            pw = busy && (!pr || $urandom_range(0, 4) == 0);
            step(pr, pw, $urandom & 32'hFFFFFFFC, $urandom,
                 $urandom_range(0, 9) < 3, $urandom_range(0, 1) == 1,
                 $urandom & 32'hFFFFFFFC, LEN_W'($urandom), $urandom);
         end
      end
      idle(40);
      for (int i = 0; i < 256; i++) check_eq("final_mem", dev_mem[i], ref_mem[i]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-ported data memory between the pipeline MEM stage and a secondary burst requester (test loader / DMA) that preloads or dumps data memory while the core runs. The pipeline has priority. The secondary port is served in cycles the MEM stage leaves idle, with an optional starvation override that stalls the pipeline. The block sits between the EX/MEM pipeline register outputs and data memory.

## Interface
Parameters:
- LEN_W, 4: width of the burst length field; a burst is 1..2^LEN_W beats.
- STARVE_MAX, 8: number of consecutive denied cycles after which the secondary port is forced through.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  reset, asynchronous, active-high.
- p_read  in  1  pipeline MEM-stage read request.
- p_write  in  1  pipeline MEM-stage write request.
- p_addr  in  32  pipeline byte address.
- p_wdata  in  32  pipeline store data.
- p_rdata  out  32  pipeline load data; combinational copy of m_rdata.
- p_stall  out  1  pipeline must hold its MEM stage this cycle.
- b_req  in  1  secondary burst request; level-sensitive.
- b_we  in  1  burst direction: 1 = write, 0 = read.
- b_addr  in  32  burst start byte address; word aligned.
- b_len  in  LEN_W  burst beats minus 1.
- b_wdata  in  32  write data for the current beat.
- b_ack  out  1  burst accepted this cycle.
- b_beat  out  1  a secondary beat occupies memory this cycle; b_wdata is consumed.
- b_rvalid  out  1  b_rdata is valid this cycle.
- b_rdata  out  32  registered read data.
- b_done  out  1  one-cycle pulse after the last beat.
- m_read, m_write  out  1 each  to data memory.
- m_addr, m_wdata  out  32 each  to data memory.
- m_rdata  in  32  from data memory (combinational read).

## Operation
- States: IDLE, XFER.
- Registers: cur_addr (32), beats_left (LEN_W), dir, starve_cnt, b_rdata, b_rvalid, b_done.
- IDLE:
  - m_* = p_* (pass-through).
  - b_ack = b_req, combinationally.
  - When b_ack=1, at the posedge: latch b_addr, b_len, b_we, and go to XFER.
- XFER, pipeline-busy cycle (p_read|p_write = 1, no force):
  - m_* = p_*; b_beat = 0.
  - starve_cnt increments, saturating at STARVE_MAX.
- XFER, free cycle, or force cycle (starve_cnt == STARVE_MAX):
  - m_addr = cur_addr; m_read = ~dir; m_write = dir; m_wdata = b_wdata; b_beat = 1.
  - p_stall = 1 only on a force cycle with a pipeline request present.
  - At the posedge: cur_addr += 4 (mod 2^32); starve_cnt = 0.
  - For a read beat, the posedge also captures b_rdata = m_rdata and sets b_rvalid = 1 for the next cycle.
- Last beat (beats_left == 0, beat taken): return to IDLE; b_done = 1 next cycle. For a read burst, b_done coincides with the final b_rvalid.
- b_req is ignored outside IDLE. Re-asserting b_req in the b_done cycle is accepted immediately.
- p_read and p_write both high is passed through unchanged and counts as busy.
- p_rdata always equals m_rdata. During a secondary beat, its value is meaningless to the pipeline.

## Timing
- Reset (asynchronous): state IDLE; cur_addr, beats_left, starve_cnt = 0; b_rvalid, b_done = 0; b_rdata = 0.
- With no pipeline request during reset, m_read and m_write are 0. p_stall, b_ack, and b_beat are 0 during reset.
- Acceptance to first beat: at least 1 cycle.
- Read data latency: 1 cycle after the beat.
- A burst of N beats with no pipeline traffic occupies N consecutive cycles after the ack cycle.
- Worst-case wait for a secondary beat: STARVE_MAX+1 cycles.
- Reset mid-burst: the burst is aborted; no b_done is issued; memory writes already performed stand.
- Memory writes occur on negedge clk inside the beat cycle, so the arbiter holds m_* stable for the whole cycle.

## Configuration
- DMEM_ARB_STARVE_EN defined: starvation counter and force cycles are present as described.
- DMEM_ARB_STARVE_EN undefined: starve_cnt is removed; p_stall is tied to 0; secondary beats occur only in pipeline-free cycles, with unbounded wait.

## Test plan
- Idle bus, b_req with b_we=1, b_addr=0x40, b_len=3, write words 1..4 → b_ack in cycle 0; b_beat in cycles 1–4 with m_addr 0x40, 0x44, 0x48, 0x4C; b_done in cycle 5; memory words 16–19 = 1..4.
- Read burst of 2 beats at 0x0 with memory preloaded to 16817 and 16801 → b_rvalid in 2 consecutive cycles with b_rdata 16817 then 16801; b_done with the second.
- Write burst while p_read is held high continuously, STARVE_MAX=8 → 8 busy cycles, then a force cycle with p_stall=1 and b_beat=1; starve_cnt returns to 0. With the macro off, no beat occurs and p_stall stays 0.
- Alternating p_write and idle cycles during a 4-beat read → beats fall only in idle cycles; pipeline writes land at p_addr unchanged; b_done after the 4th beat.
- Assert rst asynchronously mid-burst after beat 2 of 4 → outputs reach reset values immediately; no b_done; a new b_req after rst deasserts is acked.
- b_addr=0xFFFFFFFC, b_len=1 → second beat m_addr = 0x00000000.
